regfile_arbiter: RTL and testbench
==================================

// Module: regfile_arbiter
// PURPOSE
//   Shares the 4-entry x 8-bit register file (single write port, single comb read port)
//   between two requesters. Grants at most one access per cycle, round-robin.
//   After reset, clears all entries before accepting traffic. Returns read data one cycle after grant.
//   Sits between the requester logic and the register file: drives RF_WE, RF_WADDR, RF_WDATA and RF_RADDR.
// PARAMETERS
//   WIDTH      8   data width of each entry
//   ADDR_BITS  2   address width; DEPTH = 2**ADDR_BITS entries
// PORTS
//   CLK          in   1          rising-edge clock, shared with register file
//   RESET        in   1          synchronous, active-high reset
//   REQ0_VALID   in   1          requester 0 has an access pending
//   REQ0_WRITE   in   1          1 = write, 0 = read
//   REQ0_ADDR    in   ADDR_BITS  entry address
//   REQ0_WDATA   in   WIDTH      write data (ignored for reads)
//   REQ0_READY   out  1          access granted this cycle
//   RSP0_VALID   out  1          read data valid (one-cycle pulse)
//   RSP0_DATA    out  WIDTH      read data
//   REQ1_* / RSP1_*              identical set for requester 1
//   RF_WE        out  1          register file write enable
//   RF_WADDR     out  ADDR_BITS  register file write address
//   RF_WDATA     out  WIDTH      register file write data
//   RF_RADDR     out  ADDR_BITS  register file read address
//   RF_RDATA     in   WIDTH      register file combinational read data
//   INIT_DONE    out  1          high once the clear sequence completes
// BEHAVIOUR
//   Reset values: state=INIT, clr_cnt=0, pri=0, RSPn_VALID=0, RSPn_DATA=0, INIT_DONE=0.
//   INIT state:
//     - RF_WE=1, RF_WADDR=clr_cnt, RF_WDATA=0; clr_cnt increments each cycle.
//     - REQn_READY=0.
//     - Moves to RUN after the write to DEPTH-1 (DEPTH cycles). INIT_DONE=1 from the first RUN cycle.
//   RUN state: grant is combinational from REQn_VALID and pri.
//     - Only one requester valid: that requester is granted.
//     - Both valid: requester pri is granted.
//     - After any grant, pri <= ~granted index. With no grant, pri holds.
//     - REQn_READY = RUN & grant_n. A transfer is VALID & READY in the same cycle.
//     - Requester holds VALID/WRITE/ADDR/WDATA stable until READY. VALID never depends on READY.
//   Write grant in cycle C: RF_WE=1, RF_WADDR=ADDR, RF_WDATA=WDATA. Entry is updated at the end of C.
//   Read grant in cycle C:
//     - RF_RADDR=ADDR; RF_RDATA is captured into RSPn_DATA at the end of C.
//     - RSPn_VALID=1 for exactly cycle C+1. Read latency is 1 cycle.
//     - No response backpressure.
//   No grant, or a write grant: RF_WE=0 (writes only) and RF_RADDR=0. RSPn_DATA holds its last value.
//   Read-after-write to the same address in C+1 returns the new data. Write-then-read ordering is by grant order.
//   Back-to-back reads by one requester (VALID held high, other idle): a grant every cycle, a response every cycle.
//   RESET mid-operation:
//     - Drops any in-flight response (RSPn_VALID=0 next cycle).
//     - Returns to INIT and re-clears all entries.
// STRUCTURE
//   Shared package regfile_pkg:
//     - WIDTH, ADDR_BITS, DEPTH constants.
//     - State enum {INIT, RUN}.
//     - Request struct {write, addr, wdata}.
//   Sub-module rr_arb2: 2-way round-robin arbiter (VALID[1:0], pri register, GRANT[1:0] one-hot).
//   Top level holds the INIT counter, the RF port muxing and the response registers.
// TESTING
//   Model: behavioural 4x8 register file (write on edge, combinational read).
//   1. Reset, then idle:
//      -> RF_WE=1 for 4 cycles with addresses 0,1,2,3 and data 0x00.
//      -> INIT_DONE=1 in cycle 5.
//      -> READY=0 throughout INIT.
//   2. REQ0 writes 0x03 to addr 2; REQ1 reads addr 2 in the following cycle
//      -> RSP1_VALID=1 one cycle after its grant, RSP1_DATA=0x03.
//   3. Both valid for 6 cycles (REQ0 reads addr 1, REQ1 reads addr 3)
//      -> grants alternate 0,1,0,1,0,1.
//      -> each RSP_VALID pulses with that requester's entry.
//   4. Only REQ1 valid for 3 cycles -> REQ1_READY=1 on every one of them.
//      Then both valid -> REQ0 is granted first (pri=0).
//   5. Assert RESET the cycle after a read grant
//      -> no RSP_VALID pulse.
//      -> the full INIT clear repeats.
//      -> a read of an entry previously written with 0x02 returns 0x00.
//   6. REQ0 holds VALID while in INIT
//      -> no READY until the first RUN cycle, then granted immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file arbiter.
// Imported by the interface, the arbiter and the testbench.
package regfile_pkg;

   localparam int WIDTH     = 8;
   localparam int ADDR_BITS = 2;
   localparam int DEPTH     = 2 ** ADDR_BITS;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   typedef struct packed {
      logic                 write;
      logic [ADDR_BITS-1:0] addr;
      logic [WIDTH-1:0]     wdata;
   } req_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester and register-file bundle seen by the arbiter.
// master = requesters plus register file, slave = arbiter.
interface regfile_arbiter_if;
   import regfile_pkg::*;

   logic [1:0]            valid;
   req_t [1:0]            req;
   logic [1:0]            ready;
   logic [1:0]            rsp_valid;
   logic [1:0][WIDTH-1:0] rsp_data;

   logic                  rf_we;
   logic [ADDR_BITS-1:0]  rf_waddr;
   logic [WIDTH-1:0]      rf_wdata;
   logic [ADDR_BITS-1:0]  rf_raddr;
   logic [WIDTH-1:0]      rf_rdata;

   modport master (
      output valid, req, rf_rdata,
      input  ready, rsp_valid, rsp_data,
      input  rf_we, rf_waddr, rf_wdata, rf_raddr
   );

   modport slave (
      input  valid, req, rf_rdata,
      output ready, rsp_valid, rsp_data,
      output rf_we, rf_waddr, rf_wdata, rf_raddr
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a single priority bit.
// The loser of a contested cycle wins the next one.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] grant
);

   logic pri;

   always_comb begin
      grant = 2'b00;
      if (en) begin
         unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pri ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   // Priority moves to the requester that was not served.
   always_ff @(posedge clk) begin
      if (rst) begin
         pri <= 1'b0;
      end else if (|grant) begin
         pri <= grant[0];
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin access to a 4x8 register file for two requesters.
// Clears every entry after reset; reads answer one cycle after grant.
module regfile_arbiter
   import regfile_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET,
   regfile_arbiter_if.slave   bus,
   output logic               INIT_DONE
);

   state_t               state;
   state_t               state_nxt;
   logic [ADDR_BITS-1:0] clr_cnt;
   logic [1:0]           grant;
   logic [1:0]           rd_grant;
   logic                 run;
   req_t                 sel;

   assign run = (state == RUN);

   rr_arb2 u_arb (
      .clk   (CLK),
      .rst   (RESET),
      .en    (run),
      .valid (bus.valid),
      .grant (grant)
   );

   assign sel      = grant[1] ? bus.req[1] : bus.req[0];
   assign rd_grant = grant & ~{bus.req[1].write, bus.req[0].write};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= INIT;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         INIT: begin
            if (clr_cnt == ADDR_BITS'(DEPTH - 1)) begin
               state_nxt = RUN;
            end
         end
         RUN: state_nxt = RUN;
      endcase
   end

   always_comb begin
      bus.ready    = 2'b00;
      bus.rf_we    = 1'b0;
      bus.rf_waddr = '0;
      bus.rf_wdata = '0;
      bus.rf_raddr = '0;
      INIT_DONE    = 1'b0;
      unique case (state)
         INIT: begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = clr_cnt;
         end
         RUN: begin
            INIT_DONE = 1'b1;
            bus.ready = grant;
            if (|grant) begin
               if (sel.write) begin
                  bus.rf_we    = 1'b1;
                  bus.rf_waddr = sel.addr;
                  bus.rf_wdata = sel.wdata;
               end else begin
                  bus.rf_raddr = sel.addr;
               end
            end
         end
      endcase
   end

   // Read data is captured in the grant cycle and held until the next read.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         bus.rsp_valid <= '0;
         bus.rsp_data  <= '0;
      end else begin
         bus.rsp_valid <= rd_grant;
         for (int i = 0; i < 2; i++) begin
            if (rd_grant[i]) begin
               bus.rsp_data[i] <= bus.rf_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter against a register-file model.
// The bench also plays the two requesters and the register file.
module tb_regfile_arbiter;
   import regfile_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic init_done;
   logic scramble;
   int   errors = 0;
   int   checks = 0;

   regfile_arbiter_if bus ();

   regfile_arbiter dut (
      .CLK       (clk),
      .RESET     (rst),
      .bus       (bus),
      .INIT_DONE (init_done)
   );

   always #5 clk = ~clk;

   logic [WIDTH-1:0] rf_mem [DEPTH];
   assign bus.rf_rdata = rf_mem[bus.rf_raddr];

   always @(posedge clk) begin
      if (scramble) begin
         for (int i = 0; i < DEPTH; i++) rf_mem[i] <= WIDTH'($urandom);
      end else if (bus.rf_we === 1'b1) begin
         rf_mem[bus.rf_waddr] <= bus.rf_wdata;
      end
   end

   // Reference model state
   bit [WIDTH-1:0]        m_mem [DEPTH];
   int                    m_clr;
   bit                    m_pri;
   bit [1:0]              m_rv;
   bit [1:0][WIDTH-1:0]   m_rd;

   // Predicted combinational outputs for the current cycle
   bit [1:0]              e_g;
   bit                    e_we;
   bit [ADDR_BITS-1:0]    e_waddr;
   bit [ADDR_BITS-1:0]    e_raddr;
   bit [WIDTH-1:0]        e_wdata;
   bit                    e_done;

   task automatic predict();
      e_g     = 2'b00;
      e_we    = 1'b0;
      e_waddr = '0;
      e_wdata = '0;
      e_raddr = '0;
      e_done  = (m_clr >= DEPTH);
      if (!e_done) begin
         e_we    = 1'b1;
         e_waddr = m_clr[ADDR_BITS-1:0];
      end else begin
         if (bus.valid[0] && (!bus.valid[1] || !m_pri)) e_g = 2'b01;
         else if (bus.valid[1]) e_g = 2'b10;
         for (int i = 0; i < 2; i++) begin
            if (e_g[i]) begin
               if (bus.req[i].write) begin
                  e_we    = 1'b1;
                  e_waddr = bus.req[i].addr;
                  e_wdata = bus.req[i].wdata;
               end else begin
                  e_raddr = bus.req[i].addr;
               end
            end
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      predict();
   endtask

   task automatic commit();
      bit [1:0]            rv;
      bit [1:0][WIDTH-1:0] rd;
      @(posedge clk);
      rv = 2'b00;
      rd = m_rd;
      for (int i = 0; i < 2; i++) begin
         if (e_g[i] && !bus.req[i].write) begin
            rv[i] = 1'b1;
            rd[i] = m_mem[e_raddr];
         end
      end
      if (e_we) m_mem[e_waddr] = e_wdata;
      if (rst) begin
         m_clr = 0;
         m_pri = 1'b0;
         m_rv  = '0;
         m_rd  = '0;
      end else begin
         m_rv = rv;
         m_rd = rd;
         if (m_clr < DEPTH) m_clr++;
         if (e_g[0]) m_pri = 1'b1;
         else if (e_g[1]) m_pri = 1'b0;
      end
      #1;
   endtask

   task automatic set_req(input int i, input bit w,
                          input int a, input int d);
      bus.req[i].write = w;
      bus.req[i].addr  = ADDR_BITS'(a);
      bus.req[i].wdata = WIDTH'(d);
   endtask

   task automatic test_reset();
      bus.valid = 2'b00;
      set_req(0, 0, 0, 0);
      set_req(1, 0, 0, 0);
      rst      = 1'b1;
      scramble = 1'b1;
      sample();
      commit();
      scramble = 1'b0;
      sample();
      commit();
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         sample();
         checks++;
         if (bus.rf_we !== 1'b1 || bus.rf_waddr !== ADDR_BITS'(i) ||
             bus.rf_wdata !== 8'h00) begin
            errors++;
            $display("FAIL init_clear[%0d]: we=%b addr=%0d data=%h want 1/%0d/00",
                     i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, i);
         end
         checks++;
         if (bus.ready !== 2'b00 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_ready[%0d]: ready=%b done=%b want 00/0",
                     i, bus.ready, init_done);
         end
         checks++;
         if (bus.rsp_valid !== 2'b00 || bus.rsp_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b data=%h want 00/0000",
                     bus.rsp_valid, bus.rsp_data);
         end
         commit();
      end
      sample();
      checks++;
      if (init_done !== 1'b1 || bus.rf_we !== 1'b0) begin
         errors++;
         $display("FAIL init_done: done=%b we=%b want 1/0", init_done, bus.rf_we);
      end
      commit();
   endtask

   task automatic test_read_after_write();
      set_req(0, 1, 2, 8'h03);
      bus.valid = 2'b01;
      sample();
      checks++;
      if (bus.ready !== 2'b01 || bus.rf_we !== 1'b1 ||
          bus.rf_waddr !== 2'd2 || bus.rf_wdata !== 8'h03) begin
         errors++;
         $display("FAIL raw_write: ready=%b we=%b addr=%0d data=%h want 01/1/2/03",
                  bus.ready, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      end
      commit();
      set_req(1, 0, 2, 0);
      bus.valid = 2'b10;
      sample();
      checks++;
      if (bus.ready !== 2'b10 || bus.rf_we !== 1'b0 || bus.rf_raddr !== 2'd2) begin
         errors++;
         $display("FAIL raw_read: ready=%b we=%b raddr=%0d want 10/0/2",
                  bus.ready, bus.rf_we, bus.rf_raddr);
      end
      commit();
      bus.valid = 2'b00;
      sample();
      checks++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_data[1] !== 8'h03) begin
         errors++;
         $display("FAIL raw_rsp: valid=%b data=%h want 10/03",
                  bus.rsp_valid, bus.rsp_data[1]);
      end
      commit();
   endtask

   task automatic test_alternate();
      int d1;
      int d3;
      bit [1:0] want;
      d1 = $urandom_range(0, 255);
      d3 = $urandom_range(0, 255);
      set_req(0, 1, 1, d1);
      bus.valid = 2'b01;
      sample();
      commit();
      set_req(1, 1, 3, d3);
      bus.valid = 2'b10;
      sample();
      commit();
      set_req(0, 0, 1, 0);
      set_req(1, 0, 3, 0);
      bus.valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         want = (k % 2 == 1) ? 2'b10 : 2'b01;
         sample();
         checks++;
         if (bus.ready !== want) begin
            errors++;
            $display("FAIL alt_grant[%0d]: ready=%b want %b", k, bus.ready, want);
         end
         checks++;
         if (bus.rsp_valid !== m_rv || bus.rsp_data !== m_rd) begin
            errors++;
            $display("FAIL alt_rsp[%0d]: valid=%b data=%h want %b/%h",
                     k, bus.rsp_valid, bus.rsp_data, m_rv, m_rd);
         end
         commit();
      end
      bus.valid = 2'b00;
      sample();
      checks++;
      if (bus.rsp_valid !== 2'b10 ||
          bus.rsp_data !== {WIDTH'(d3), WIDTH'(d1)}) begin
         errors++;
         $display("FAIL alt_last: valid=%b data=%h want 10/%h%h",
                  bus.rsp_valid, bus.rsp_data, d3[7:0], d1[7:0]);
      end
      commit();
   endtask

   task automatic test_back_to_back();
      bus.valid = 2'b10;
      for (int k = 0; k < 3; k++) begin
         set_req(1, 0, $urandom_range(0, DEPTH - 1), 0);
         sample();
         checks++;
         if (bus.ready !== 2'b10) begin
            errors++;
            $display("FAIL b2b_grant[%0d]: ready=%b want 10", k, bus.ready);
         end
         checks++;
         if (bus.rsp_valid !== m_rv || bus.rsp_data !== m_rd) begin
            errors++;
            $display("FAIL b2b_rsp[%0d]: valid=%b data=%h want %b/%h",
                     k, bus.rsp_valid, bus.rsp_data, m_rv, m_rd);
         end
         commit();
      end
      set_req(0, 0, 2, 0);
      bus.valid = 2'b11;
      sample();
      checks++;
      if (bus.ready !== 2'b01 || bus.rsp_valid !== 2'b10) begin
         errors++;
         $display("FAIL b2b_pri: ready=%b rsp=%b want 01/10",
                  bus.ready, bus.rsp_valid);
      end
      commit();
      bus.valid = 2'b00;
      sample();
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_data[0] !== m_rd[0]) begin
         errors++;
         $display("FAIL b2b_tail: valid=%b data=%h want 01/%h",
                  bus.rsp_valid, bus.rsp_data[0], m_rd[0]);
      end
      commit();
   endtask

   task automatic test_reset_mid();
      set_req(0, 1, 0, 8'h02);
      bus.valid = 2'b01;
      sample();
      commit();
      set_req(0, 0, 0, 0);
      rst = 1'b1;
      sample();
      checks++;
      if (bus.ready !== 2'b01) begin
         errors++;
         $display("FAIL mid_grant: ready=%b want 01", bus.ready);
      end
      commit();
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         sample();
         checks++;
         if (bus.rsp_valid !== 2'b00 || bus.ready !== 2'b00) begin
            errors++;
            $display("FAIL mid_init[%0d]: rsp=%b ready=%b want 00/00",
                     i, bus.rsp_valid, bus.ready);
         end
         checks++;
         if (bus.rf_we !== 1'b1 || bus.rf_waddr !== ADDR_BITS'(i) ||
             init_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear[%0d]: we=%b addr=%0d done=%b want 1/%0d/0",
                     i, bus.rf_we, bus.rf_waddr, init_done, i);
         end
         commit();
      end
      sample();
      checks++;
      if (bus.ready !== 2'b01 || init_done !== 1'b1) begin
         errors++;
         $display("FAIL mid_first_run: ready=%b done=%b want 01/1",
                  bus.ready, init_done);
      end
      commit();
      bus.valid = 2'b00;
      sample();
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_data[0] !== 8'h00) begin
         errors++;
         $display("FAIL mid_cleared: valid=%b data=%h want 01/00",
                  bus.rsp_valid, bus.rsp_data[0]);
      end
      commit();
   endtask

   task automatic test_random();
      bit [1:0] pend;
      pend = 2'b00;
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < 65) begin
               pend[i] = 1'b1;
               set_req(i, 1'($urandom), $urandom_range(0, DEPTH - 1),
                       $urandom_range(0, 255));
            end
         end
         bus.valid = pend;
         rst = ($urandom_range(0, 79) == 0);
         sample();
         checks++;
         if (bus.ready !== e_g || init_done !== e_done) begin
            errors++;
            $display("FAIL rnd_grant[%0d]: ready=%b done=%b want %b/%b",
                     k, bus.ready, init_done, e_g, e_done);
         end
         checks++;
         if (bus.rsp_valid !== m_rv || bus.rsp_data !== m_rd) begin
            errors++;
            $display("FAIL rnd_rsp[%0d]: valid=%b data=%h want %b/%h",
                     k, bus.rsp_valid, bus.rsp_data, m_rv, m_rd);
         end
         checks++;
         if (bus.rf_we !== e_we || bus.rf_raddr !== e_raddr) begin
            errors++;
            $display("FAIL rnd_rf[%0d]: we=%b raddr=%0d want %b/%0d",
                     k, bus.rf_we, bus.rf_raddr, e_we, e_raddr);
         end
         if (e_we) begin
            checks++;
            if (bus.rf_waddr !== e_waddr || bus.rf_wdata !== e_wdata) begin
               errors++;
               $display("FAIL rnd_wr[%0d]: addr=%0d data=%h want %0d/%h",
                        k, bus.rf_waddr, bus.rf_wdata, e_waddr, e_wdata);
            end
         end
         pend = pend & ~e_g;
         commit();
      end
      rst = 1'b0;
      bus.valid = 2'b00;
   endtask

   initial begin
      test_reset();
      test_read_after_write();
      test_alternate();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
